// File: rtl/cfg_pkg.sv
// Shared parser configuration constants and the config-lookup response record.
package cfg_pkg;

  localparam int CFG_ADDR_WIDTH = 4;
  localparam int CFG_DATA_WIDTH = 32;
  localparam int CFG_TAG_WIDTH  = 4;

  typedef struct packed {
    logic [CFG_DATA_WIDTH-1:0] data;
    logic [CFG_TAG_WIDTH-1:0]  tag;
  } cfg_rsp_t;

endpackage

// File: rtl/cfg_rsp_fifo.sv
// Synchronous FIFO with occupancy count, flush and a held read port.
// When empty, the read port keeps showing the last entry it presented (0 after reset).
module cfg_rsp_fifo #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hold_q;
  logic             not_empty;
  logic             do_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign not_empty = (cnt_q != '0);
  assign do_pop    = pop_i & not_empty;

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      if (not_empty) hold_q <= mem_q[rd_ptr_q];
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        case ({push_i, do_pop})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign rdata_o = not_empty ? mem_q[rd_ptr_q] : hold_q;
  assign cnt_o   = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && (cnt_q == CNT_W'(DEPTH)) && !do_pop));

endmodule

// File: rtl/cfg_fetch.sv
// Config lookup front-end for cfg_ram: issues the ROM address on accept, captures the
// word one cycle later with its tag, and buffers responses against downstream stalls.
module cfg_fetch
  import cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = CFG_ADDR_WIDTH,
  parameter int DATA_WIDTH = CFG_DATA_WIDTH,
  parameter int TAG_WIDTH  = CFG_TAG_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FW    = DATA_WIDTH + TAG_WIDTH;

  logic                 s1_valid_q, s1_valid_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W:0]       occ;
  logic [FW-1:0]        fifo_rdata;
  logic                 acc;

  assign rom_addr = req_addr;

  // Accept only while every read already in flight plus this one has a FIFO slot.
  assign occ       = {1'b0, cnt} + {{CNT_W{1'b0}}, s1_valid_q};
  assign req_ready = (occ < (CNT_W + 1)'(FIFO_DEPTH));
  assign acc       = req_valid & req_ready;

  always_comb begin
    s1_valid_d = acc & ~flush;
    s1_tag_d   = acc ? req_tag : s1_tag_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  cfg_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (flush),
    .push_i  (s1_valid_q),
    .wdata_i ({rom_dout, s1_tag_q}),
    .pop_i   (rsp_ready),
    .rdata_o (fifo_rdata),
    .cnt_o   (cnt)
  );

  assign rsp_valid           = (cnt != '0);
  assign {rsp_data, rsp_tag} = fifo_rdata;
  assign busy                = s1_valid_q | (cnt != '0);

endmodule

// File: tb/tb_cfg_fetch.sv
// Bench for cfg_fetch: ROM model, accept-side scoreboard push, response-side monitor.
module tb_cfg_fetch;
  import cfg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_addr = '0;
  logic [3:0]  req_tag = '0;
  logic [3:0]  rom_addr;
  logic [31:0] rom_dout = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int rsp_seen = 0;
  cfg_rsp_t exp_q[$];

  cfg_fetch #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TAG_WIDTH(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // cfg_ram model: word[a] = A5A5_0000 + a, one cycle read latency
  always @(posedge clk) rom_dout <= 32'hA5A5_0000 + 32'(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus side: record the expected response at every accepted request
  always @(negedge clk) begin : acc_track
    cfg_rsp_t e;
    if (rst) begin
      if (flush) exp_q.delete();
      else if (req_valid && req_ready) begin
        e.data = 32'hA5A5_0000 + 32'(req_addr);
        e.tag  = req_tag;
        exp_q.push_back(e);
      end
    end
  end

  // Response side: compare every handshaken response against the queue head
  always @(negedge clk) begin : rsp_mon
    cfg_rsp_t e;
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got data %0h tag %0h, expected no response", rsp_data, rsp_tag);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      end
      rsp_seen++;
    end
  end

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid || busy) && n < max) begin
      tick();
      n++;
    end
    check(name, 32'(n < max), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0, acc, sent, guard;

    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #2 rst = 1'b1;
    tick();

    // Single lookup: addr 3 tag 5, response 2 cycles after accept
    rsp_ready = 1'b1;
    seen0 = rsp_seen;
    check("single_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = 4'd3; req_tag = 4'd5;
    tick();
    req_valid = 1'b0;
    check("single_lat1_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("single_lat2_valid", 32'(rsp_valid), 32'd1);
    check("single_data", rsp_data, 32'hA5A5_0003);
    check("single_tag", 32'(rsp_tag), 32'd5);
    tick();
    check("single_busy_after", 32'(busy), 32'd0);
    check("single_count", 32'(rsp_seen - seen0), 32'd1);

    // Back-to-back addresses 0..15 with rsp_ready held high
    seen0 = rsp_seen;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_addr = 4'(i); req_tag = 4'(15 - i);
      check("b2b_req_ready", 32'(req_ready), 32'd1);
      tick();
      if (i > 0) check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    req_valid = 1'b0;
    tick();
    check("b2b_last_valid", 32'(rsp_valid), 32'd1);
    tick();
    check("b2b_done_valid", 32'(rsp_valid), 32'd0);
    check("b2b_count", 32'(rsp_seen - seen0), 32'd16);

    // Backpressure: exactly FIFO_DEPTH requests accepted while rsp_ready is low
    rsp_ready = 1'b0;
    seen0 = rsp_seen;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = 4'(8 + acc); req_tag = 4'(acc);
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_held_data", rsp_data, 32'hA5A5_0008);
    rsp_ready = 1'b1;
    wait_drain("bp_drain", 20);
    check("bp_count", 32'(rsp_seen - seen0), 32'd4);
    check("bp_resume_ready", 32'(req_ready), 32'd1);

    // Random backpressure over 200 requests, pointers wrap many times
    seen0 = rsp_seen;
    sent = 0;
    guard = 0;
    while (sent < 200 && guard < 5000) begin
      req_valid = 1'b1;
      req_addr  = 4'($urandom_range(0, 15));
      req_tag   = 4'($urandom_range(0, 15));
      rsp_ready = 1'($urandom_range(0, 1));
      if (req_ready) sent++;
      tick();
      guard++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check("rand_sent", 32'(sent), 32'd200);
    wait_drain("rand_drain", 40);
    check("rand_count", 32'(rsp_seen - seen0), 32'd200);

    // Flush with two buffered and one in s1
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 4'(1 + i); req_tag = 4'(i);
      check("flush_fill_ready", 32'(req_ready), 32'd1);
      tick();
    end
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    rsp_ready = 1'b1;
    seen0 = rsp_seen;
    req_valid = 1'b1; req_addr = 4'd7; req_tag = 4'd9;
    tick();
    req_valid = 1'b0;
    tick();
    check("flush_post_data", rsp_data, 32'hA5A5_0007);
    check("flush_post_tag", 32'(rsp_tag), 32'd9);
    wait_drain("flush_drain", 10);
    check("flush_post_count", 32'(rsp_seen - seen0), 32'd1);

    // Asynchronous reset mid-stream, between clock edges
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 4'(i); req_tag = 4'(i);
      tick();
    end
    #3;
    rst = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    #1;
    check("areset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("areset_req_ready", 32'(req_ready), 32'd1);
    check("areset_busy", 32'(busy), 32'd0);
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
    rsp_ready = 1'b1;
    seen0 = rsp_seen;
    req_valid = 1'b1; req_addr = 4'd5; req_tag = 4'd2;
    tick();
    req_valid = 1'b0;
    wait_drain("areset_drain", 10);
    check("areset_post_count", 32'(rsp_seen - seen0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
